// File: rtl/ysyx_23060171_idu_ctrl_if.sv
// Handshake and retire bus between IFU, IDU issue control, EXU and WBU.
// The master side is the surrounding pipeline; the slave side is the issue controller.
interface ysyx_23060171_idu_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       writes_rd;
  logic       is_serial;
  logic       out_valid;
  logic       out_ready;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       wb_writes;

  modport master (
    output in_valid, rs1, rs2, rd, uses_rs1, uses_rs2, writes_rd, is_serial,
    output out_ready, wb_valid, wb_rd, wb_writes,
    input  in_ready, out_valid
  );

  modport slave (
    input  in_valid, rs1, rs2, rd, uses_rs1, uses_rs2, writes_rd, is_serial,
    input  out_ready, wb_valid, wb_rd, wb_writes,
    output in_ready, out_valid
  );
endinterface

// File: rtl/ysyx_23060171_idu_ctrl.sv
// Decode-stage issue controller: GPR write scoreboard (RAW/WAW gating),
// in-flight instruction bound, and serialization of CSR/system instructions.
module ysyx_23060171_idu_ctrl #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  ysyx_23060171_idu_ctrl_if.slave bus,
  output logic [31:0]            busy_mask,
  output logic [CNT_W-1:0]       outstanding,
  output logic                   serial_busy,
  output logic                   err
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SERIAL = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);

  // A pending write to x0 never exists, so index 0 always reads as free.
  function automatic logic reg_busy(input logic [31:0] mask, input logic [4:0] idx);
    reg_busy = (idx != 5'd0) & mask[idx];
  endfunction

  state_e           state_q, state_d;
  logic [31:0]      busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic raw_s;
  logic waw_s;
  logic cap_ok_s;
  logic serial_ok_s;
  logic can_issue_s;
  logic fire_s;
  logic dec_s;

  // Issue decision from registered scoreboard state only (no retire bypass).
  always_comb begin
    raw_s       = (bus.uses_rs1 & reg_busy(busy_q, bus.rs1)) |
                  (bus.uses_rs2 & reg_busy(busy_q, bus.rs2));
    waw_s       = bus.writes_rd & reg_busy(busy_q, bus.rd);
    cap_ok_s    = (cnt_q < CNT_MAX);
    serial_ok_s = !bus.is_serial | (cnt_q == CNT_ZERO);
    can_issue_s = !raw_s & !waw_s & cap_ok_s & (state_q == ST_RUN) & serial_ok_s;
    fire_s      = bus.in_valid & bus.out_ready & can_issue_s;
    dec_s       = bus.wb_valid & (cnt_q != CNT_ZERO);
  end

  assign bus.out_valid = bus.in_valid & can_issue_s;
  assign bus.in_ready  = bus.out_ready & can_issue_s;

  // Serialization FSM: drain the pipeline before a serial op, then hold until it retires.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (fire_s && bus.is_serial) begin
          state_d = ST_SERIAL;
        end else if (bus.in_valid && bus.is_serial && (cnt_q != CNT_ZERO)) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_SERIAL: begin
        if (bus.wb_valid) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_SERIAL;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // In-flight counter and sticky underflow error.
  always_comb begin
    cnt_d = cnt_q;
    case ({fire_s, dec_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    err_d = err_q | (bus.wb_valid & (cnt_q == CNT_ZERO));
  end

  // Scoreboard: clear on retire, set on issue; WAW gating keeps the two indices distinct.
  always_comb begin
    busy_d = busy_q;
    if (bus.wb_valid && bus.wb_writes && (bus.wb_rd != 5'd0)) begin
      busy_d[bus.wb_rd] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (fire_s && bus.writes_rd && (bus.rd != 5'd0)) begin
      busy_d[bus.rd] = 1'b1;
    end else begin
      busy_d[bus.rd] = busy_d[bus.rd];
    end
    busy_d[0] = 1'b0;
  end

  // State registers with immediate asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      busy_q  <= 32'h0000_0000;
      cnt_q   <= CNT_ZERO;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign busy_mask   = busy_q;
  assign outstanding = cnt_q;
  assign serial_busy = (state_q != ST_RUN);
  assign err         = err_q;

endmodule

// File: tb/tb_ysyx_23060171_idu_ctrl.sv
// Scoreboard-driven bench for the decode issue controller.
module tb_ysyx_23060171_idu_ctrl;

  typedef struct packed {
    logic       iv;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       u1;
    logic       u2;
    logic       wr;
    logic       ser;
    logic       ordy;
    logic       wbv;
    logic [4:0] wbrd;
    logic       wbw;
  } stim_t;

  typedef struct packed {
    logic        ov;
    logic        ir;
    logic [31:0] busy;
    logic [2:0]  outst;
    logic        sb;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] busy_mask;
  logic [2:0]  outstanding;
  logic        serial_busy;
  logic        err;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  exp_t sb_q[$];

  ysyx_23060171_idu_ctrl_if bus();

  ysyx_23060171_idu_ctrl #(.MAX_OUTSTANDING(4), .CNT_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy_mask   (busy_mask),
    .outstanding (outstanding),
    .serial_busy (serial_busy),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mk_s(input logic iv, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic u1, input logic u2,
                                 input logic wr, input logic ser, input logic ordy,
                                 input logic wbv, input logic [4:0] wbrd, input logic wbw);
    stim_t s;
    s.iv = iv; s.rs1 = rs1; s.rs2 = rs2; s.rd = rd; s.u1 = u1; s.u2 = u2;
    s.wr = wr; s.ser = ser; s.ordy = ordy; s.wbv = wbv; s.wbrd = wbrd; s.wbw = wbw;
    return s;
  endfunction

  function automatic exp_t mk_e(input logic ov, input logic ir, input logic [31:0] busy,
                                input logic [2:0] outst, input logic sb, input logic er);
    exp_t e;
    e.ov = ov; e.ir = ir; e.busy = busy; e.outst = outst; e.sb = sb; e.err = er;
    return e;
  endfunction

  function automatic exp_t sample();
    return mk_e(bus.out_valid, bus.in_ready, busy_mask, outstanding, serial_busy, err);
  endfunction

  function automatic string fmt(input exp_t e);
    return $sformatf("ov=%b ir=%b busy=%h outst=%0d sbusy=%b err=%b",
                     e.ov, e.ir, e.busy, e.outst, e.sb, e.err);
  endfunction

  task automatic drive(input stim_t s);
    bus.in_valid  = s.iv;
    bus.rs1       = s.rs1;
    bus.rs2       = s.rs2;
    bus.rd        = s.rd;
    bus.uses_rs1  = s.u1;
    bus.uses_rs2  = s.u2;
    bus.writes_rd = s.wr;
    bus.is_serial = s.ser;
    bus.out_ready = s.ordy;
    bus.wb_valid  = s.wbv;
    bus.wb_rd     = s.wbrd;
    bus.wb_writes = s.wbw;
  endtask

  task automatic test_reset();
    stim_t s;
    exp_t  obs, e;
    @(negedge clk);
    drive(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    sb_q.push_back(mk_e(0, 0, 32'h0, 3'd0, 0, 0));
    #1;
    obs = sample(); e = sb_q.pop_front(); chk_cnt++;
    if (obs !== e) $display("FAIL reset_idle: got %s, expected %s", fmt(obs), fmt(e));
    else pass_cnt++;
    @(negedge clk);
    s = mk_s(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    drive(s);
    sb_q.push_back(mk_e(1, 1, 32'h0, 3'd0, 0, 0));
    #1;
    obs = sample(); e = sb_q.pop_front(); chk_cnt++;
    if (obs !== e) $display("FAIL reset_passthru: got %s, expected %s", fmt(obs), fmt(e));
    else pass_cnt++;
    @(negedge clk);
    drive(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
  endtask

  task automatic test_raw();
    stim_t st_q[$]; exp_t ex_q[$]; exp_t obs, e; int step = 0;
    st_q.push_back(mk_s(1, 5'd0, 5'd0, 5'd5, 1, 0, 1, 0, 1, 0, 5'd0, 0)); ex_q.push_back(mk_e(1, 1, 32'h0,  3'd0, 0, 0));
    st_q.push_back(mk_s(1, 5'd5, 5'd0, 5'd6, 1, 0, 1, 0, 1, 0, 5'd0, 0)); ex_q.push_back(mk_e(0, 0, 32'h20, 3'd1, 0, 0));
    st_q.push_back(mk_s(1, 5'd5, 5'd0, 5'd6, 1, 0, 1, 0, 1, 1, 5'd5, 1)); ex_q.push_back(mk_e(0, 0, 32'h20, 3'd1, 0, 0));
    st_q.push_back(mk_s(1, 5'd5, 5'd0, 5'd6, 1, 0, 1, 0, 1, 0, 5'd0, 0)); ex_q.push_back(mk_e(1, 1, 32'h0,  3'd0, 0, 0));
    st_q.push_back(mk_s(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 1, 5'd6, 1)); ex_q.push_back(mk_e(0, 1, 32'h40, 3'd1, 0, 0));
    st_q.push_back(mk_s(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 5'd0, 0)); ex_q.push_back(mk_e(0, 0, 32'h0,  3'd0, 0, 0));
    while (st_q.size() > 0) begin
      @(negedge clk);
      drive(st_q.pop_front());
      sb_q.push_back(ex_q.pop_front());
      #1;
      obs = sample(); e = sb_q.pop_front(); chk_cnt++;
      if (obs !== e) $display("FAIL raw step %0d: got %s, expected %s", step, fmt(obs), fmt(e));
      else pass_cnt++;
      step++;
    end
  endtask

  task automatic test_x0_waw();
    stim_t st_q[$]; exp_t ex_q[$]; exp_t obs, e; int step = 0;
    st_q.push_back(mk_s(1, 0, 0, 5'd0, 0, 0, 1, 0, 1, 0, 5'd0, 0)); ex_q.push_back(mk_e(1, 1, 32'h0,  3'd0, 0, 0));
    st_q.push_back(mk_s(1, 0, 0, 5'd7, 0, 0, 1, 0, 1, 0, 5'd0, 0)); ex_q.push_back(mk_e(1, 1, 32'h0,  3'd1, 0, 0));
    st_q.push_back(mk_s(1, 0, 0, 5'd7, 0, 0, 1, 0, 1, 0, 5'd0, 0)); ex_q.push_back(mk_e(0, 0, 32'h80, 3'd2, 0, 0));
    st_q.push_back(mk_s(1, 0, 0, 5'd7, 0, 0, 1, 0, 1, 1, 5'd0, 1)); ex_q.push_back(mk_e(0, 0, 32'h80, 3'd2, 0, 0));
    st_q.push_back(mk_s(1, 0, 0, 5'd7, 0, 0, 1, 0, 1, 1, 5'd7, 1)); ex_q.push_back(mk_e(0, 0, 32'h80, 3'd1, 0, 0));
    st_q.push_back(mk_s(1, 0, 0, 5'd7, 0, 0, 1, 0, 1, 0, 5'd0, 0)); ex_q.push_back(mk_e(1, 1, 32'h0,  3'd0, 0, 0));
    st_q.push_back(mk_s(0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 1, 5'd7, 1)); ex_q.push_back(mk_e(0, 0, 32'h80, 3'd1, 0, 0));
    st_q.push_back(mk_s(0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 5'd0, 0)); ex_q.push_back(mk_e(0, 0, 32'h0,  3'd0, 0, 0));
    while (st_q.size() > 0) begin
      @(negedge clk);
      drive(st_q.pop_front());
      sb_q.push_back(ex_q.pop_front());
      #1;
      obs = sample(); e = sb_q.pop_front(); chk_cnt++;
      if (obs !== e) $display("FAIL x0_waw step %0d: got %s, expected %s", step, fmt(obs), fmt(e));
      else pass_cnt++;
      step++;
    end
  endtask

  task automatic test_capacity();
    stim_t st_q[$]; exp_t ex_q[$]; exp_t obs, e; int step = 0;
    for (int k = 0; k < 4; k++) begin
      st_q.push_back(mk_s(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); ex_q.push_back(mk_e(1, 1, 32'h0, 3'(k), 0, 0));
    end
    st_q.push_back(mk_s(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); ex_q.push_back(mk_e(0, 0, 32'h0, 3'd4, 0, 0));
    st_q.push_back(mk_s(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0)); ex_q.push_back(mk_e(0, 0, 32'h0, 3'd4, 0, 0));
    st_q.push_back(mk_s(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); ex_q.push_back(mk_e(1, 1, 32'h0, 3'd3, 0, 0));
    st_q.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); ex_q.push_back(mk_e(0, 0, 32'h0, 3'd4, 0, 0));
    st_q.push_back(mk_s(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0)); ex_q.push_back(mk_e(1, 1, 32'h0, 3'd3, 0, 0));
    st_q.push_back(mk_s(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); ex_q.push_back(mk_e(1, 1, 32'h0, 3'd3, 0, 0));
    for (int k = 4; k > 0; k--) begin
      st_q.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); ex_q.push_back(mk_e(0, 0, 32'h0, 3'(k), 0, 0));
    end
    st_q.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex_q.push_back(mk_e(0, 0, 32'h0, 3'd0, 0, 0));
    while (st_q.size() > 0) begin
      @(negedge clk);
      drive(st_q.pop_front());
      sb_q.push_back(ex_q.pop_front());
      #1;
      obs = sample(); e = sb_q.pop_front(); chk_cnt++;
      if (obs !== e) $display("FAIL capacity step %0d: got %s, expected %s", step, fmt(obs), fmt(e));
      else pass_cnt++;
      step++;
    end
  endtask

  task automatic test_serial();
    stim_t st_q[$]; exp_t ex_q[$]; exp_t obs, e; int step = 0;
    st_q.push_back(mk_s(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); ex_q.push_back(mk_e(1, 1, 32'h0, 3'd0, 0, 0));
    st_q.push_back(mk_s(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); ex_q.push_back(mk_e(1, 1, 32'h0, 3'd1, 0, 0));
    st_q.push_back(mk_s(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0)); ex_q.push_back(mk_e(0, 0, 32'h0, 3'd2, 0, 0));
    st_q.push_back(mk_s(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0)); ex_q.push_back(mk_e(0, 0, 32'h0, 3'd2, 1, 0));
    st_q.push_back(mk_s(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0)); ex_q.push_back(mk_e(0, 0, 32'h0, 3'd1, 1, 0));
    st_q.push_back(mk_s(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0)); ex_q.push_back(mk_e(0, 0, 32'h0, 3'd0, 1, 0));
    st_q.push_back(mk_s(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0)); ex_q.push_back(mk_e(1, 1, 32'h0, 3'd0, 0, 0));
    st_q.push_back(mk_s(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); ex_q.push_back(mk_e(0, 0, 32'h0, 3'd1, 1, 0));
    st_q.push_back(mk_s(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0)); ex_q.push_back(mk_e(0, 0, 32'h0, 3'd1, 1, 0));
    st_q.push_back(mk_s(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); ex_q.push_back(mk_e(1, 1, 32'h0, 3'd0, 0, 0));
    st_q.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); ex_q.push_back(mk_e(0, 0, 32'h0, 3'd1, 0, 0));
    st_q.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex_q.push_back(mk_e(0, 0, 32'h0, 3'd0, 0, 0));
    while (st_q.size() > 0) begin
      @(negedge clk);
      drive(st_q.pop_front());
      sb_q.push_back(ex_q.pop_front());
      #1;
      obs = sample(); e = sb_q.pop_front(); chk_cnt++;
      if (obs !== e) $display("FAIL serial step %0d: got %s, expected %s", step, fmt(obs), fmt(e));
      else pass_cnt++;
      step++;
    end
  endtask

  task automatic test_error();
    stim_t st_q[$]; exp_t ex_q[$]; exp_t obs, e; int step = 0;
    st_q.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); ex_q.push_back(mk_e(0, 0, 32'h0, 3'd0, 0, 0));
    st_q.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex_q.push_back(mk_e(0, 0, 32'h0, 3'd0, 0, 1));
    st_q.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); ex_q.push_back(mk_e(0, 0, 32'h0, 3'd0, 0, 1));
    st_q.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex_q.push_back(mk_e(0, 0, 32'h0, 3'd0, 0, 1));
    while (st_q.size() > 0) begin
      @(negedge clk);
      drive(st_q.pop_front());
      sb_q.push_back(ex_q.pop_front());
      #1;
      obs = sample(); e = sb_q.pop_front(); chk_cnt++;
      if (obs !== e) $display("FAIL error step %0d: got %s, expected %s", step, fmt(obs), fmt(e));
      else pass_cnt++;
      step++;
    end
  endtask

  task automatic test_reset_mid();
    stim_t st_q[$]; exp_t ex_q[$]; exp_t obs, e; int step = 0;
    st_q.push_back(mk_s(1, 0, 0, 5'd4, 0, 0, 1, 0, 1, 0, 0, 0)); ex_q.push_back(mk_e(1, 1, 32'h0,  3'd0, 0, 1));
    st_q.push_back(mk_s(1, 0, 0, 5'd0, 0, 0, 0, 0, 1, 0, 0, 0)); ex_q.push_back(mk_e(1, 1, 32'h10, 3'd1, 0, 1));
    st_q.push_back(mk_s(1, 0, 0, 5'd0, 0, 0, 0, 1, 1, 0, 0, 0)); ex_q.push_back(mk_e(0, 0, 32'h10, 3'd2, 0, 1));
    st_q.push_back(mk_s(0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0)); ex_q.push_back(mk_e(0, 0, 32'h10, 3'd2, 1, 1));
    while (st_q.size() > 0) begin
      @(negedge clk);
      drive(st_q.pop_front());
      sb_q.push_back(ex_q.pop_front());
      #1;
      obs = sample(); e = sb_q.pop_front(); chk_cnt++;
      if (obs !== e) $display("FAIL reset_mid step %0d: got %s, expected %s", step, fmt(obs), fmt(e));
      else pass_cnt++;
      step++;
    end
    // Assert reset between clock edges; state must clear before the next rising edge.
    #2;
    rst = 1'b1;
    sb_q.push_back(mk_e(0, 0, 32'h0, 3'd0, 0, 0));
    #1;
    obs = sample(); e = sb_q.pop_front(); chk_cnt++;
    if (obs !== e) $display("FAIL reset_async: got %s, expected %s", fmt(obs), fmt(e));
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    test_reset();
    test_raw();
    test_x0_waw();
    test_capacity();
    test_serial();
    test_error();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
